// File: rtl/dcache_controller_if.sv
// CPU-side and memory-side signal bundle for dcache_controller.
// slave: the cache's view; master: the CPU/memory side that drives requests and acks.
interface dcache_controller_if;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic         cpu_MemRead_i;
    logic         cpu_MemWrite_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    modport slave (
        input  cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i, mem_data_i, mem_ack_i,
        output cpu_data_o, cpu_stall_o, mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
    );

    modport master (
        output cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i, mem_data_i, mem_ack_i,
        input  cpu_data_o, cpu_stall_o, mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
    );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache with a 256-bit req/ack refill port.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_controller #(
    parameter int unsigned LINE_COUNT = 32
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    dcache_controller_if.slave bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]        hit_count_o,
    output logic [31:0]        miss_count_o
`endif
);
    localparam int unsigned IW = $clog2(LINE_COUNT);
    localparam int unsigned TW = 27 - IW;

    typedef enum logic [1:0] {IDLE, MISS, WRITEBACK, REFILL} state_t;
    state_t state, state_n;

    logic [LINE_COUNT-1:0] valid_q;
    logic [LINE_COUNT-1:0] dirty_q;
    logic [TW-1:0]         tag_mem  [LINE_COUNT];
    logic [255:0]          data_mem [LINE_COUNT];

    logic [IW-1:0] idx;
    logic [TW-1:0] req_tag;
    logic [7:0]    word_lsb;
    logic [255:0]  line;
    logic          req, is_read, is_write, hit, idle_hit, refill_ack;
    logic          unused_addr_bits;

    assign idx              = bus.cpu_addr_i[5+IW-1:5];
    assign req_tag          = bus.cpu_addr_i[31:5+IW];
    assign word_lsb         = {bus.cpu_addr_i[4:2], 5'b0};
    assign unused_addr_bits = ^bus.cpu_addr_i[1:0];

    assign is_write   = bus.cpu_MemWrite_i;
    assign is_read    = bus.cpu_MemRead_i & ~bus.cpu_MemWrite_i;
    assign req        = bus.cpu_MemWrite_i | bus.cpu_MemRead_i;
    assign line       = data_mem[idx];
    assign hit        = req & valid_q[idx] & (tag_mem[idx] == req_tag);
    assign idle_hit   = (state == IDLE) & hit;
    assign refill_ack = (state == REFILL) & bus.mem_ack_i;

    always_comb begin
        state_n         = state;
        bus.cpu_stall_o = 1'b0;
        bus.cpu_data_o  = '0;
        case (state)
            IDLE: begin
                if (req && !hit) begin
                    state_n         = MISS;
                    bus.cpu_stall_o = 1'b1;
                end else if (hit && is_read) begin
                    bus.cpu_data_o = line[word_lsb +: 32];
                end
            end
            MISS: begin
                bus.cpu_stall_o = 1'b1;
                state_n = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : REFILL;
            end
            WRITEBACK: begin
                bus.cpu_stall_o = 1'b1;
                if (bus.mem_ack_i) state_n = REFILL;
            end
            REFILL: begin
                bus.cpu_stall_o = 1'b1;
                if (bus.mem_ack_i) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // The combinational CPU outputs must read 0 while reset is asserted.
        if (!rst_n_i) begin
            bus.cpu_stall_o = 1'b0;
            bus.cpu_data_o  = '0;
        end
    end

    // Memory-side outputs load only on a state change, so they hold for the whole transaction.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state            <= IDLE;
            bus.mem_enable_o <= 1'b0;
            bus.mem_write_o  <= 1'b0;
            bus.mem_addr_o   <= '0;
            bus.mem_data_o   <= '0;
        end else begin
            state <= state_n;
            if (state_n != state) begin
                bus.mem_enable_o <= (state_n == WRITEBACK) || (state_n == REFILL);
                bus.mem_write_o  <= (state_n == WRITEBACK);
                bus.mem_data_o   <= (state_n == WRITEBACK) ? line : '0;
                case (state_n)
                    WRITEBACK: bus.mem_addr_o <= {tag_mem[idx], idx, 5'b0};
                    REFILL:    bus.mem_addr_o <= {req_tag, idx, 5'b0};
                    default:   bus.mem_addr_o <= '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (refill_ack) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (idle_hit && is_write) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (refill_ack) begin
            data_mem[idx] <= bus.mem_data_i;
            tag_mem[idx]  <= req_tag;
        end else if (idle_hit && is_write) begin
            data_mem[idx][word_lsb +: 32] <= bus.cpu_data_i;
        end
    end

`ifdef DCACHE_STATS_EN
    logic after_refill;

    // The completion cycle right after a refill is part of the miss, not a new hit.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hit_count_o  <= '0;
            miss_count_o <= '0;
            after_refill <= 1'b0;
        end else begin
            after_refill <= refill_ack;
            if ((state == IDLE) && (state_n == MISS) && (miss_count_o != '1))
                miss_count_o <= miss_count_o + 32'd1;
            if (idle_hit && !after_refill && (hit_count_o != '1))
                hit_count_o <= hit_count_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: a flat-memory model predicts load data, write-back
// contents and miss timing; a responder process plays the slow off-chip memory.
module tb_dcache_controller;
    localparam int unsigned LINES = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    dcache_controller_if bus ();
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    dcache_controller #(.LINE_COUNT(LINES)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .bus          (bus)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count_o  (hit_count),
        .miss_count_o (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Backing memory and the CPU-visible memory image, word-addressed.
    logic [31:0] mem_words [int unsigned];
    logic [31:0] view      [int unsigned];
    bit          m_valid [LINES];
    bit          m_dirty [LINES];
    int unsigned m_tag   [LINES];

    function automatic logic [31:0] dflt(input int unsigned a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction
    function automatic logic [31:0] get_mem(input int unsigned a);
        int unsigned k = a & ~32'd3;
        return mem_words.exists(k) ? mem_words[k] : dflt(k);
    endfunction
    function automatic logic [31:0] get_view(input int unsigned a);
        int unsigned k = a & ~32'd3;
        return view.exists(k) ? view[k] : get_mem(k);
    endfunction

    // Memory responder state.
    int          wb_dly = 1;
    int          rf_dly = 1;          // 0 = never ack
    int          wb_seen = 0;
    int          rf_seen = 0;
    int          late_ack_req = 0;
    logic [31:0] exp_wb_addr = '0;
    logic [31:0] exp_rf_addr = '0;
    logic [31:0] last_wb_addr = '0;
    logic [31:0] last_rf_addr = '0;
    logic [255:0] last_wb_data = '0;

    initial begin
        int          cnt = 0;
        int          late_done = 0;
        int          dly;
        logic [32:0] h_ctl;
        logic [255:0] h_data;
        logic [255:0] ln;
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = '0;
        forever begin
            @(negedge clk);
            bus.mem_ack_i = 1'b0;
            if (late_ack_req != late_done) begin
                late_done      = late_ack_req;
                bus.mem_ack_i  = 1'b1;
                bus.mem_data_i = '1;
                cnt = 0;
                continue;
            end
            if (!rst_n || !bus.mem_enable_o) begin
                cnt = 0;
                continue;
            end
            cnt++;
            if (cnt == 1) begin
                h_ctl  = {bus.mem_write_o, bus.mem_addr_o};
                h_data = bus.mem_data_o;
            end else begin
                check("mem_hold_ctl", {bus.mem_write_o, bus.mem_addr_o}, h_ctl);
                check("mem_hold_data", bus.mem_data_o, h_data);
            end
            dly = bus.mem_write_o ? wb_dly : rf_dly;
            if (dly != 0 && cnt == dly) begin
                if (bus.mem_write_o) begin
                    wb_seen++;
                    last_wb_addr = bus.mem_addr_o;
                    last_wb_data = bus.mem_data_o;
                    check("wb_addr", bus.mem_addr_o, exp_wb_addr);
                    for (int unsigned w = 0; w < 8; w++)
                        ln[32*w +: 32] = get_view(bus.mem_addr_o + 4*w);
                    check("wb_line", bus.mem_data_o, ln);
                    for (int unsigned w = 0; w < 8; w++)
                        mem_words[bus.mem_addr_o + 4*w] = bus.mem_data_o[32*w +: 32];
                end else begin
                    rf_seen++;
                    last_rf_addr = bus.mem_addr_o;
                    check("rf_addr", bus.mem_addr_o, exp_rf_addr);
                    for (int unsigned w = 0; w < 8; w++)
                        ln[32*w +: 32] = get_mem(bus.mem_addr_o + 4*w);
                    bus.mem_data_i = ln;
                end
                bus.mem_ack_i = 1'b1;
                cnt = 0;
            end
        end
    end

    // Every cycle out of reset: loads that complete must return the memory image; otherwise data is 0.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (!bus.cpu_stall_o && bus.cpu_MemWrite_i) begin
                    check("store_data_zero", bus.cpu_data_o, 32'h0);
                    view[bus.cpu_addr_i & ~32'd3] = bus.cpu_data_i;
                end else if (!bus.cpu_stall_o && bus.cpu_MemRead_i)
                    check("load_data", bus.cpu_data_o, get_view(bus.cpu_addr_i));
                else
                    check("no_hit_data_zero", bus.cpu_data_o, 32'h0);
            end
        end
    end

    task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int rfd, input int wbd, output logic [31:0] rdata);
        int unsigned idx = (addr >> 5) % LINES;
        int unsigned tag = addr / (32 * LINES);
        bit exp_miss = !(m_valid[idx] && m_tag[idx] == tag);
        bit exp_wb   = exp_miss && m_dirty[idx];
        int exp_stall = exp_miss ? 2 + rfd + (exp_wb ? wbd : 0) : 0;
        int wb0 = wb_seen;
        int rf0 = rf_seen;
        int stalls = 0;
        bit done = 0;
        exp_wb_addr = m_tag[idx] * 32 * LINES + idx * 32;
        exp_rf_addr = addr & ~32'd31;
        rf_dly = rfd;
        wb_dly = wbd;
        rdata  = '0;
        @(posedge clk); #1;
        bus.cpu_addr_i     = addr;
        bus.cpu_data_i     = wdata;
        bus.cpu_MemWrite_i = wr;
        bus.cpu_MemRead_i  = !wr;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!bus.cpu_stall_o) begin
                done = 1;
                break;
            end
            stalls++;
        end
        if (!done) check("access_timeout", 1'b0, 1'b1);
        rdata = bus.cpu_data_o;
        if (!exp_miss) check("hit_mem_idle", bus.mem_enable_o, 1'b0);
        check("stall_cycles", stalls, exp_stall);
        check("wb_count", wb_seen - wb0, exp_wb);
        check("rf_count", rf_seen - rf0, exp_miss);
        m_valid[idx] = 1;
        m_tag[idx]   = tag;
        m_dirty[idx] = exp_miss ? wr : (m_dirty[idx] | wr);
        @(posedge clk); #1;
        bus.cpu_MemRead_i  = 1'b0;
        bus.cpu_MemWrite_i = 1'b0;
    endtask

    task automatic model_reset();
        foreach (m_valid[i]) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
        end
        view = mem_words;
    endtask

    initial begin
        logic [31:0] rd;
        bus.cpu_addr_i     = 32'h44;
        bus.cpu_data_i     = '0;
        bus.cpu_MemRead_i  = 1'b1;
        bus.cpu_MemWrite_i = 1'b0;
        mem_words[32'h44] = 32'hDEAD_BEEF;
        model_reset();

        // Reset state with a pending request.
        repeat (2) @(negedge clk);
        check("rst_stall", bus.cpu_stall_o, 1'b0);
        check("rst_data", bus.cpu_data_o, 32'h0);
        check("rst_enable", bus.mem_enable_o, 1'b0);
        check("rst_write", bus.mem_write_o, 1'b0);
        check("rst_addr", bus.mem_addr_o, 32'h0);
        check("rst_mdata", bus.mem_data_o, 256'h0);
        @(posedge clk); #1;
        bus.cpu_MemRead_i = 1'b0;
        rst_n = 1'b1;

        // Cold read miss, then read hit on the same word.
        access(0, 32'h44, 0, 3, 1, rd);
        check("cold_read_word", rd, 32'hDEAD_BEEF);
        check("cold_refill_addr", last_rf_addr, 32'h40);
        access(0, 32'h44, 0, 3, 1, rd);
        check("hit_read_word", rd, 32'hDEAD_BEEF);

        // Dirty conflict miss at index 2.
        access(1, 32'h40, 32'h1234_5678, 1, 1, rd);
        access(0, 32'h440, 0, 1, 2, rd);
        check("wb_addr_lit", last_wb_addr, 32'h40);
        check("wb_word0_lit", last_wb_data[31:0], 32'h1234_5678);
        check("conflict_rf_addr", last_rf_addr, 32'h440);
        access(0, 32'h40, 0, 2, 1, rd);
        check("reread_written", rd, 32'h1234_5678);

        // Slow memory: 100 idle REFILL cycles, ack on the 101st.
        access(0, 32'h100, 0, 101, 1, rd);

        // Write miss allocate, read back, then a dirty conflict on index 16.
        access(1, 32'h204, 32'hCAFE_0001, 2, 1, rd);
        access(0, 32'h204, 0, 1, 1, rd);
        check("write_alloc_word", rd, 32'hCAFE_0001);
        access(0, 32'h604, 0, 1, 3, rd);
        access(0, 32'h204, 0, 2, 1, rd);
        check("after_wb_word", rd, 32'hCAFE_0001);

        // Reset during REFILL (no ack ever arrives).
        rf_dly = 0;
        @(posedge clk); #1;
        bus.cpu_addr_i    = 32'h80;
        bus.cpu_MemRead_i = 1'b1;
        repeat (6) @(negedge clk);
        check("refill_stalled", bus.cpu_stall_o, 1'b1);
        check("refill_enable", bus.mem_enable_o, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_enable", bus.mem_enable_o, 1'b0);
        check("midrst_stall", bus.cpu_stall_o, 1'b0);
        check("midrst_addr", bus.mem_addr_o, 32'h0);
        bus.cpu_MemRead_i = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        late_ack_req++;
        repeat (2) @(negedge clk);
        check("late_ack_ignored", bus.mem_enable_o, 1'b0);
        access(0, 32'h80, 0, 2, 1, rd);

`ifdef DCACHE_STATS_EN
        access(0, 32'h80, 0, 1, 1, rd);
        access(0, 32'h84, 0, 1, 1, rd);
        access(0, 32'h480, 0, 1, 1, rd);
        check("stats_hits", hit_count, 32'd2);
        check("stats_misses", miss_count, 32'd2);
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate data cache placed between the pipelined CPU's MEM stage and a slow off-chip data memory. It replaces the single-cycle Data_Memory port. Hits complete in the requesting cycle. Misses stall the whole pipeline while the controller writes back a dirty victim line and refills through a 256-bit req/ack memory handshake.

## Interface
- `LINE_COUNT`, default 32: number of lines; must be a power of two, ≥2. Index width `IW = log2(LINE_COUNT)`; tag = `addr[31:5+IW]`.
- `clk_i` in 1: clock, rising edge.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `cpu_addr_i` in 32: byte address. `[4:2]` is the word offset, `[5+IW-1:5]` is the index, `[1:0]` is ignored.
- `cpu_data_i` in 32: store data.
- `cpu_MemRead_i` in 1: load request.
- `cpu_MemWrite_i` in 1: store request. It wins if both requests are high.
- `cpu_data_o` in→out 32: load data; 0 when there is no read hit.
- `cpu_stall_o` out 1: freeze PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- `mem_addr_o` out 32: line-aligned address, `[4:0]=0`.
- `mem_data_o` out 256: victim line for write-back.
- `mem_enable_o` out 1: memory request.
- `mem_write_o` out 1: 1 = write-back, 0 = refill.
- `mem_data_i` in 256: refill line, valid while `mem_ack_i` is high.
- `mem_ack_i` in 1: one-cycle completion pulse.

## Operation
- **Storage.** Each line holds valid, dirty, tag and 256 data bits. Word w sits at bits `[32w+31:32w]`.
- **Hit.** A hit requires a request, valid set and a tag match.
- **State machine.** States are IDLE, MISS, WRITEBACK, REFILL.
  - IDLE, no request: no action.
  - IDLE, hit: stall is 0. A read drives `cpu_data_o` combinationally. A write updates the word at the edge and sets dirty.
  - IDLE, miss: `cpu_stall_o=1` combinationally. Go to MISS.
  - MISS: stall is 1. If the victim is valid and dirty, go to WRITEBACK; otherwise go to REFILL.
  - WRITEBACK: `mem_enable_o=1`, `mem_write_o=1`, `mem_addr_o={victim tag, index, 5'b0}`, `mem_data_o`=victim line. On `mem_ack_i`, go to REFILL.
  - REFILL: `mem_enable_o=1`, `mem_write_o=0`, `mem_addr_o={req tag, index, 5'b0}`. On `mem_ack_i`, store `mem_data_i`, set valid=1, dirty=0, write the tag, and go to IDLE.
  - IDLE after a refill: the held request now hits and completes as a normal hit. A write sets dirty here.
- **Stall rule.** `cpu_stall_o` is 1 in MISS, WRITEBACK and REFILL, and in IDLE on a miss.
- **Request stability.** CPU request signals are held by the stalled pipeline and are sampled again in IDLE.

## Timing
- **Reset.** While `rst_n_i=0`, asynchronously:
  - state=IDLE;
  - all valid and dirty bits are 0;
  - `mem_enable_o`, `mem_write_o`, `cpu_stall_o`, `cpu_data_o`, `mem_addr_o` and `mem_data_o` are 0.
  - Tag and data arrays are not reset.
- **Hit latency.** 0 extra cycles.
- **Clean miss.** Stall lasts 1 (IDLE) + 1 (MISS) + N_r cycles, where N_r counts REFILL cycles up to and including the ack. The access then completes in the next IDLE cycle.
- **Dirty miss.** Add the WRITEBACK cycles, up to and including the write-back ack.
- **Handshake hold.** `mem_enable_o`, `mem_write_o`, `mem_addr_o` and `mem_data_o` are registered from state. They stay stable from state entry until the cycle after the ack is sampled.
- **Ack timing.** The earliest legal ack is in the first cycle `mem_enable_o` is high. An ack received while `mem_enable_o=0`, or in state MISS, is ignored.
- **No timeout.** An ack that never arrives keeps the cache in WRITEBACK or REFILL indefinitely.
- **Reset mid-transaction.** `mem_enable_o` drops immediately. The line being refilled stays invalid. A late ack after reset is ignored.

## Configuration
- `DCACHE_STATS_EN` defined: adds output ports `hit_count_o` (32) and `miss_count_o` (32), both reset to 0 and saturating at `32'hFFFF_FFFF`.
  - `miss_count_o` increments on each IDLE→MISS transition.
  - `hit_count_o` increments on each IDLE hit, except the completion cycle immediately after REFILL.
- `DCACHE_STATS_EN` undefined: the ports and counters do not exist. Behaviour is otherwise identical.

## Test plan
- **Cold read miss.** After reset, read 0x0000_0040. Required: stall=1; MISS lasts 1 cycle; then `mem_enable_o=1`, `mem_write_o=0`, `mem_addr_o=0x40`. Ack 3 cycles later with word 1 = 0xDEAD_BEEF. Required: next cycle stall=0 and `cpu_data_o=0xDEAD_BEEF` for address 0x44.
- **Read hit.** Re-read 0x44. Required: stall=0 in that same cycle, data 0xDEAD_BEEF, `mem_enable_o` stays 0.
- **Dirty conflict miss.** Write 0x1234_5678 to 0x40, then read 0x440 (same index 2, tag 1). Required:
  - a WRITEBACK to `mem_addr_o=0x40` with `mem_data_o[31:0]=0x1234_5678`;
  - after its ack, a REFILL to 0x440;
  - the read then completes.
- **Slow memory.** Hold `mem_ack_i=0` for 100 cycles in REFILL. Required: stall and all `mem_*` outputs unchanged for all 100 cycles. One ack then ends the miss.
- **Reset mid-refill.** Pulse `rst_n_i` low during REFILL. Required: `mem_enable_o=0` at once. A subsequent read to the same address misses again.
- **Stats (with `DCACHE_STATS_EN`).** Run the sequence: cold miss, hit, hit, conflict miss. Required: `hit_count_o=2`, `miss_count_o=2`.
